// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the data-memory bridge: FSM state encoding and bus size codes.
package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/dmem_bridge_if.sv
// Core M-stage port plus simple req/addr_ok/data_ok bus port of the data-memory bridge.
interface dmem_bridge_if;

    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        longest_stall;
    logic [31:0] mem_rdata;
    logic        mem_stall;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    // environment side: drives the core request and the bus responses
    modport master (
        output mem_en, mem_wen, mem_addr, mem_wdata, longest_stall,
        output data_addr_ok, data_data_ok, data_rdata,
        input  mem_rdata, mem_stall,
        input  data_req, data_wr, data_size, data_addr, data_wdata
    );

    // bridge side
    modport slave (
        input  mem_en, mem_wen, mem_addr, mem_wdata, longest_stall,
        input  data_addr_ok, data_data_ok, data_rdata,
        output mem_rdata, mem_stall,
        output data_req, data_wr, data_size, data_addr, data_wdata
    );

endinterface

// File: rtl/dmem_bridge_wen2size.sv
// Byte-enable to bus size decoder; purely combinational.
// Irregular enable patterns fall back to a full-word access.
module dmem_bridge_wen2size
    import dmem_bridge_pkg::*;
(
    input  logic [3:0] wen,
    output logic [1:0] size
);

    always_comb begin
        case (wen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_BYTE;
            4'b0011, 4'b1100:                   size = SIZE_HALF;
            default:                            size = SIZE_WORD;
        endcase
    end

endmodule

// File: rtl/dmem_bridge.sv
// M-stage to req/addr_ok/data_ok bus bridge, one transaction outstanding; request issued in the
// access cycle, load data returned in the data_ok cycle; the core is stalled until data_ok.
module dmem_bridge
    import dmem_bridge_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    dmem_bridge_if.slave io
);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] rdata_r;
    logic        wr_r;
    logic [1:0]  size_r;

    logic [1:0]  size_in;
    logic        wr_in;
    logic [31:0] addr_in;
    logic        rsp_hit;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;

    dmem_bridge_wen2size u_wen2size (
        .wen  (io.mem_wen),
        .size (size_in)
    );

    assign wr_in   = |io.mem_wen;
    assign addr_in = wr_in ? io.mem_addr : {io.mem_addr[31:2], 2'b00};
    assign rsp_hit = (state == WAIT) && io.data_data_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_r  <= '0;
            wdata_r <= '0;
            wr_r    <= 1'b0;
            size_r  <= '0;
        end else if ((state == IDLE) && io.mem_en) begin
            addr_r  <= addr_in;
            wdata_r <= io.mem_wdata;
            wr_r    <= wr_in;
            size_r  <= size_in;
        end
    end

    // a response for a flushed access is consumed but never becomes load data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_r <= '0;
        end else if (rsp_hit && io.mem_en) begin
            rdata_r <= io.data_rdata;
        end
    end

    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        wr        = wr_r;
        size      = size_r;
        addr      = addr_r;
        wdata     = wdata_r;
        case (state)
            IDLE: begin
                wr    = wr_in;
                size  = size_in;
                addr  = addr_in;
                wdata = io.mem_wdata;
                if (io.mem_en) begin
                    req       = 1'b1;
                    state_nxt = io.data_addr_ok ? WAIT : REQ;
                end
            end
            REQ: begin
                req = 1'b1;
                if (io.data_addr_ok) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (io.data_data_ok) begin
                    state_nxt = (io.mem_en && io.longest_stall) ? DONE : IDLE;
                end
            end
            DONE: begin
                if (!io.longest_stall) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign io.data_req   = req & rst;
    assign io.data_wr    = wr;
    assign io.data_size  = size;
    assign io.data_addr  = addr;
    assign io.data_wdata = wdata;
    assign io.mem_stall  = rst & io.mem_en & ~rsp_hit & (state != DONE);
    assign io.mem_rdata  = rsp_hit ? io.data_rdata : rdata_r;

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: decode table, directed multi-cycle sequences, random transactions.
module tb_dmem_bridge;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_bridge_if io ();

    dmem_bridge dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] last_rd = 32'h0;

    typedef struct {
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        wr;
        logic [31:0] baddr;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // size rule stated in terms of how many lanes are enabled
    function automatic logic [1:0] ref_size(input logic [3:0] wen);
        if ($countones(wen) == 1) return 2'd0;
        if (wen == 4'b0011 || wen == 4'b1100) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [31:0] ref_addr(input logic [3:0] wen, input logic [31:0] a);
        return (wen != 4'b0000) ? a : (a & 32'hFFFF_FFFC);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One core access: addr_ok after a_dly cycles, data_ok d_dly cycles later, then post cycles in DONE.
    task automatic do_access(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int a_dly, input int d_dly, input int post);
        logic [1:0]  esz;
        logic [31:0] ea;
        esz = ref_size(wen);
        ea  = ref_addr(wen, addr);
        io.mem_en = 1'b1;
        io.mem_wen = wen;
        io.mem_addr = addr;
        io.mem_wdata = wdata;
        io.longest_stall = 1'b1;
        io.data_data_ok = 1'b0;
        for (int i = 0; i <= a_dly; i++) begin
            io.data_addr_ok = (i == a_dly);
            @(negedge clk);
            chk("req_vld", io.data_req, 1);
            chk("req_wr", io.data_wr, wen != 4'b0000);
            chk("req_size", io.data_size, esz);
            chk("req_addr", io.data_addr, ea);
            chk("req_wdata", io.data_wdata, wdata);
            chk("req_stall", io.mem_stall, 1);
            // the core moves on to other signals once accepted; the bridge must use its latched copy
            if (i > 0) begin
                io.mem_addr = $urandom;
                io.mem_wen = 4'($urandom);
                io.mem_wdata = $urandom;
            end
            next_cycle();
        end
        io.data_addr_ok = 1'b0;
        for (int i = 1; i <= d_dly; i++) begin
            io.data_data_ok = (i == d_dly);
            io.data_rdata = (i == d_dly) ? rdata : $urandom;
            io.longest_stall = (i == d_dly) ? (post > 0) : 1'b1;
            @(negedge clk);
            chk("wait_req", io.data_req, 0);
            chk("wait_stall", io.mem_stall, i != d_dly);
            if (i == d_dly) chk("rsp_rdata", io.mem_rdata, rdata);
            next_cycle();
        end
        io.data_data_ok = 1'b0;
        last_rd = rdata;
        for (int i = 0; i < post; i++) begin
            io.data_rdata = $urandom;
            io.longest_stall = (i < post - 1);
            @(negedge clk);
            chk("done_stall", io.mem_stall, 0);
            chk("done_req", io.data_req, 0);
            chk("done_rdata", io.mem_rdata, rdata);
            next_cycle();
        end
        io.mem_en = 1'b0;
        io.longest_stall = 1'b0;
    endtask

    task automatic idle_cycle(input logic ls);
        io.mem_en = 1'b0;
        io.longest_stall = ls;
        io.data_addr_ok = 1'b0;
        io.data_data_ok = 1'b0;
        io.data_rdata = $urandom;
        @(negedge clk);
        chk("idle_req", io.data_req, 0);
        chk("idle_stall", io.mem_stall, 0);
        chk("idle_rdata", io.mem_rdata, last_rd);
        next_cycle();
    endtask

    initial begin
        vt[0]  = '{4'b0000, 32'h1000_0003, 2'd2, 1'b0, 32'h1000_0000};
        vt[1]  = '{4'b0001, 32'h2000_0001, 2'd0, 1'b1, 32'h2000_0001};
        vt[2]  = '{4'b0010, 32'h2000_0001, 2'd0, 1'b1, 32'h2000_0001};
        vt[3]  = '{4'b0100, 32'h1003_0002, 2'd0, 1'b1, 32'h1003_0002};
        vt[4]  = '{4'b1000, 32'h0000_0007, 2'd0, 1'b1, 32'h0000_0007};
        vt[5]  = '{4'b0011, 32'h8000_0000, 2'd1, 1'b1, 32'h8000_0000};
        vt[6]  = '{4'b1100, 32'h8000_0002, 2'd1, 1'b1, 32'h8000_0002};
        vt[7]  = '{4'b1111, 32'h1234_5678, 2'd2, 1'b1, 32'h1234_5678};
        vt[8]  = '{4'b0110, 32'h0000_0011, 2'd2, 1'b1, 32'h0000_0011};
        vt[9]  = '{4'b0101, 32'hA5A5_A5A5, 2'd2, 1'b1, 32'hA5A5_A5A5};
        vt[10] = '{4'b0111, 32'h0000_0004, 2'd2, 1'b1, 32'h0000_0004};
        vt[11] = '{4'b0000, 32'hFFFF_FFFF, 2'd2, 1'b0, 32'hFFFF_FFFC};

        io.mem_en = 1'b1;
        io.mem_wen = 4'b0000;
        io.mem_addr = 32'h0;
        io.mem_wdata = 32'h0;
        io.longest_stall = 1'b0;
        io.data_addr_ok = 1'b1;
        io.data_data_ok = 1'b1;
        io.data_rdata = 32'hFFFF_FFFF;

        // reset state: request and stall suppressed, load data cleared even with a live access
        #2;
        chk("rst_req", io.data_req, 0);
        chk("rst_stall", io.mem_stall, 0);
        chk("rst_rdata", io.mem_rdata, 0);

        // decode table applied while the FSM is pinned in IDLE by reset
        for (int i = 0; i < 12; i++) begin
            io.mem_wen = vt[i].wen;
            io.mem_addr = vt[i].addr;
            io.mem_wdata = vt[i].addr ^ 32'h5555_AAAA;
            #1;
            chk("tbl_size", io.data_size, vt[i].size);
            chk("tbl_wr", io.data_wr, vt[i].wr);
            chk("tbl_addr", io.data_addr, vt[i].baddr);
            chk("tbl_wdata", io.data_wdata, vt[i].addr ^ 32'h5555_AAAA);
            #1;
        end

        io.mem_en = 1'b0;
        io.data_addr_ok = 1'b0;
        io.data_data_ok = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
        idle_cycle(1'b0);

        // read accepted at once, data two cycles later
        do_access(4'b0000, 32'h0000_1006, 32'h0, 32'hDEAD_BEEF, 0, 2, 0);
        idle_cycle(1'b0);

        // byte store with addr_ok held off for three cycles
        do_access(4'b0100, 32'h1003_0002, 32'h00AB_0000, 32'h0BAD_F00D, 3, 1, 0);
        idle_cycle(1'b0);

        // read completing under an external stall lasting three more cycles
        do_access(4'b0000, 32'h0000_2000, 32'h0, 32'h1234_5678, 0, 1, 3);
        idle_cycle(1'b1);

        // flush in WAIT: response absorbed, stall never raised, no DONE detour
        io.mem_en = 1'b1;
        io.mem_wen = 4'b0000;
        io.mem_addr = 32'h0000_3000;
        io.longest_stall = 1'b1;
        io.data_addr_ok = 1'b1;
        @(negedge clk);
        chk("flush_req", io.data_req, 1);
        next_cycle();
        io.mem_en = 1'b0;
        io.data_addr_ok = 1'b0;
        @(negedge clk);
        chk("flush_stall0", io.mem_stall, 0);
        chk("flush_req0", io.data_req, 0);
        next_cycle();
        io.data_data_ok = 1'b1;
        io.data_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("flush_stall1", io.mem_stall, 0);
        chk("flush_req1", io.data_req, 0);
        next_cycle();
        idle_cycle(1'b1);
        do_access(4'b0000, 32'h0000_3004, 32'h0, 32'h0F0F_0F0F, 0, 1, 0);

        // reset pulsed while waiting for addr_ok
        io.mem_en = 1'b1;
        io.mem_wen = 4'b1111;
        io.mem_addr = 32'h0000_4000;
        io.mem_wdata = 32'h7777_7777;
        io.longest_stall = 1'b1;
        @(negedge clk);
        chk("prerst_req", io.data_req, 1);
        next_cycle();
        #1 rst = 1'b0;
        #1;
        chk("midrst_req", io.data_req, 0);
        chk("midrst_stall", io.mem_stall, 0);
        chk("midrst_rdata", io.mem_rdata, 0);
        io.mem_en = 1'b0;
        io.data_addr_ok = 1'b1;
        io.data_data_ok = 1'b1;
        io.data_rdata = 32'hCAFE_CAFE;
        next_cycle();
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("postrst_req", io.data_req, 0);
        chk("postrst_stall", io.mem_stall, 0);
        chk("postrst_rdata", io.mem_rdata, 0);
        next_cycle();
        last_rd = 32'h0;
        idle_cycle(1'b0);
        do_access(4'b0000, 32'h0000_4008, 32'h0, 32'h5A5A_1234, 1, 2, 0);

        // half-word store immediately followed by a word read
        do_access(4'b1100, 32'h0000_5002, 32'hBEEF_0000, 32'h1111_2222, 0, 1, 0);
        do_access(4'b0000, 32'h0000_5003, 32'h0, 32'h3333_4444, 1, 1, 0);
        idle_cycle(1'b0);

        // random transactions against the per-access rules
        for (int n = 0; n < 60; n++) begin
            logic [3:0] w;
            case ($urandom_range(0, 4))
                0:       w = 4'b0000;
                1:       w = 4'b1111;
                2:       w = 4'b0001 << $urandom_range(0, 3);
                3:       w = $urandom_range(0, 1) ? 4'b0011 : 4'b1100;
                default: w = 4'($urandom);
            endcase
            do_access(w, $urandom, $urandom, $urandom, $urandom_range(0, 3),
                      $urandom_range(1, 3), $urandom_range(0, 1) * $urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) idle_cycle(1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
